// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, request register layout.
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int REQ_AW     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic                    write;
    logic [REQ_AW-1:0]       addr;
    logic [31:0]             wdata;
    logic [WORD_BYTES-1:0]   wstrb;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [IDX_W-1:0]      idx,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory slave with LATENCY wait states and misalign/range error reporting.
// Define DMEM_B2B_EN to let a response handshake and a new accept share one edge.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request registered, wait counter running down
// RESP  | response presented, held until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [3:0]    req_wstrb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          busy
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_t state, state_d;
  logic [3:0]  cnt;
  dmem_req_t   req_q, req_in, req_eff;
  logic        ready_q, rsp_valid_q, rsp_err_q, data_en_q, busy_q;
  logic        accept, rsp_hs, go_resp;
  logic        misaligned, out_of_range, eff_err;
  logic [31:0] arr_rdata;

  assign req_in = '{write: req_write, addr: REQ_AW'(req_addr),
                    wdata: req_wdata, wstrb: req_wstrb};

`ifdef DMEM_B2B_EN
  assign req_ready = ready_q | (rsp_valid_q & rsp_ready);
`else
  assign req_ready = ready_q;
`endif

  assign accept = req_valid & req_ready;
  assign rsp_hs = rsp_valid_q & rsp_ready;

  // With zero latency the storage access happens on the accept edge itself,
  // so the check and the array see the live request rather than the register.
  assign req_eff      = (state == WAIT) ? req_q : req_in;
  assign misaligned   = |req_eff.addr[1:0];
  assign out_of_range = {2'b00, req_eff.addr[REQ_AW-1:2]} >= 32'(DEPTH_WORDS);
  assign eff_err      = misaligned | out_of_range;

  assign go_resp = ((state == WAIT) && (cnt == 4'd0)) || (accept && (LATENCY == 0));

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) state_d = RESP;
          else              state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          if (!accept)           state_d = IDLE;
          else if (LATENCY == 0) state_d = RESP;
          else                   state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      req_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      data_en_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_d;
      ready_q     <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
      if (accept) begin
        req_q <= req_in;
        cnt   <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (go_resp) begin
        rsp_err_q <= eff_err;
        data_en_q <= !req_eff.write && !eff_err;
      end else if (rsp_hs) begin
        rsp_err_q <= 1'b0;
        data_en_q <= 1'b0;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (go_resp && req_eff.write && !eff_err),
    .re    (go_resp && !req_eff.write && !eff_err),
    .idx   (req_eff.addr[2 +: IDX_W]),
    .be    (req_eff.wstrb),
    .wdata (req_eff.wdata),
    .rdata (arr_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = data_en_q ? arr_rdata : 32'd0;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps, randomized traffic against a word-map model,
// and a zero-latency streaming check on a second instance.
module tb_dmem_responder;

  localparam int DEPTH    = 1024;
  localparam int LAT      = 2;
  localparam int D0_DEPTH = 16;
`ifdef DMEM_B2B_EN
  localparam int EXP_GAP = 1;
`else
  localparam int EXP_GAP = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        d0_req_valid = 1'b0, d0_req_write = 1'b0, d0_rsp_ready = 1'b0;
  logic [31:0] d0_req_addr = '0, d0_req_wdata = '0;
  logic [3:0]  d0_req_wstrb = 4'hF;
  logic        d0_req_ready, d0_rsp_valid, d0_rsp_err, d0_busy;
  logic [31:0] d0_rsp_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .AW(32)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(D0_DEPTH), .LATENCY(0), .AW(32)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(d0_req_valid), .req_ready(d0_req_ready),
    .req_write(d0_req_write), .req_addr(d0_req_addr), .req_wdata(d0_req_wdata),
    .req_wstrb(d0_req_wstrb), .rsp_valid(d0_rsp_valid), .rsp_ready(d0_rsp_ready),
    .rsp_rdata(d0_rsp_rdata), .rsp_err(d0_rsp_err), .busy(d0_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on u_dut; hold = cycles rsp_ready stays low once rsp_valid is seen.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] ws, input int hold, input logic hold_valid,
                     output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_seen", 32'(n < 20), 32'd1);
    @(negedge clk);
    req_valid = hold_valid; req_write = ~wr; req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    n = 1;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk("latency", 32'(n), 32'(LAT + 1));
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", 32'(rsp_err), 32'(er));
      if (hold_valid) chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  logic [31:0] d0_mem [D0_DEPTH];
  logic [31:0] d0_wd [4];

  task automatic stream0(input logic wr);
    logic [31:0] exp_q[$];
    bit pend;
    int sent, got, last, guard;
    sent = 0; got = 0; last = 0; guard = 0; pend = 1'b0;
    d0_rsp_ready = 1'b1;
    while (got < 4 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (pend) begin
        if (wr) begin d0_mem[sent + 3] = d0_wd[sent]; exp_q.push_back(32'd0); end
        else exp_q.push_back(d0_mem[sent + 3]);
        sent++;
      end
      if (d0_rsp_valid) begin
        chk("b2b_rdata", d0_rsp_rdata, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0);
        chk("b2b_err", 32'(d0_rsp_err), 32'd0);
        if (got > 0) chk("b2b_gap", 32'(cyc - last), 32'(EXP_GAP));
        last = cyc;
        got++;
      end
      d0_req_valid = (sent < 4);
      d0_req_write = wr;
      d0_req_addr  = 32'((sent + 3) * 4);
      d0_req_wdata = d0_wd[sent % 4];
      pend = d0_req_valid && d0_req_ready;
    end
    chk("b2b_count", 32'(got), 32'd4);
    d0_req_valid = 1'b0;
    @(negedge clk);
    d0_rsp_ready = 1'b0;
  endtask

  logic [31:0] mdl [int];

  initial begin
    logic [31:0] rd, addr, wd, rd_e, mask;
    logic er, err_e, wr;
    logic [3:0] ws;
    int k, idx, w;

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er);
    chk("store_rdata", rd, 32'd0); chk("store_err", 32'(er), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("load_rdata", rd, 32'hDEADBEEF); chk("load_err", 32'(er), 32'd0);

    txn(1'b1, 32'h14, 32'h11223344, 4'hF, 1, 1'b0, rd, er);
    txn(1'b1, 32'h14, 32'h0000AA00, 4'h2, 0, 1'b0, rd, er);
    txn(1'b0, 32'h14, 32'h0, 4'h0, 2, 1'b0, rd, er);
    chk("partial_rdata", rd, 32'h1122AA44);

    txn(1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("misalign_err", 32'(er), 32'd1); chk("misalign_rdata", rd, 32'd0);

    txn(1'b1, 32'((DEPTH - 1) * 4), 32'hCAFEF00D, 4'hF, 0, 1'b0, rd, er);
    txn(1'b1, 32'(DEPTH * 4), 32'h0BADF00D, 4'hF, 0, 1'b0, rd, er);
    chk("oor_err", 32'(er), 32'd1);
    txn(1'b0, 32'((DEPTH - 1) * 4), 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("last_word_kept", rd, 32'hCAFEF00D); chk("last_word_err", 32'(er), 32'd0);

    txn(1'b1, 32'h10, 32'h12121212, 4'h0, 0, 1'b0, rd, er);
    chk("nostrb_err", 32'(er), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, rd, er);
    chk("nostrb_kept", rd, 32'hDEADBEEF);

    // abandon a store mid-WAIT with an asynchronous reset
    txn(1'b1, 32'h20, 32'h12345678, 4'hF, 0, 1'b0, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h55555555; req_wstrb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", {28'd0, req_ready, rsp_valid, rsp_err, busy}, 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("midrst_old_value", rd, 32'h12345678);

    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 9);
      idx = $urandom_range(0, 8);
      wr = 1'($urandom_range(0, 1));
      if (idx == 8) idx = DEPTH - 1;
      addr = 32'(idx * 4);
      if (k == 0) addr = addr | 32'($urandom_range(1, 3));
      else if (k == 1) addr = 32'((DEPTH + $urandom_range(0, 100)) * 4);
      w = int'(addr >> 2);
      err_e = (addr % 4 != 0) || (w >= DEPTH);
      if (!wr && !err_e && !mdl.exists(w)) wr = 1'b1;
      wd = $urandom;
      ws = 4'($urandom);
      if (wr && !err_e && !mdl.exists(w)) ws = 4'hF;
      txn(wr, addr, wd, ws, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, er);
      rd_e = 32'd0;
      if (!err_e) begin
        if (wr) begin
          mask = '0;
          for (int b = 0; b < 4; b++) if (ws[b]) mask = mask | (32'hFF << (8 * b));
          mdl[w] = mdl.exists(w) ? ((mdl[w] & ~mask) | (wd & mask)) : wd;
        end else begin
          rd_e = mdl[w];
        end
      end
      chk("rnd_err", 32'(er), 32'(err_e));
      chk("rnd_rdata", rd, rd_e);
    end

    for (int i = 0; i < 4; i++) d0_wd[i] = $urandom;
    stream0(1'b1);
    stream0(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
